// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Cleans up the raw push-button levels from the board KEY pins so that mode,
// selection and display logic only ever see well-behaved signals. Every key
// channel is an identical, independent pipeline:
//
//   KEY pin -> 2-flop synchronizer -> polarity normalize (1 = pressed)
//           -> debounce FSM -> level + press/release/repeat strobes
//
// Parameters
//   NUM_KEYS        number of key channels
//   DEBOUNCE_CYCLES stable synchronized samples needed to accept a change (>= 1)
//   REPEAT_DELAY    cycles from press acceptance to the first repeat strobe,
//                   0 turns auto-repeat off
//   REPEAT_PERIOD   cycles between later repeat strobes (>= 1)
//   ACTIVE_LOW      1: pin reads 0 while pressed, 0: pin reads 1 while pressed
//
// Ports
//   CLOCK50        system clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   KEY            raw asynchronous button levels
//   pressed        debounced level, 1 while the key is held
//   press_pulse    one-cycle strobe when a press is accepted
//   release_pulse  one-cycle strobe when a release is accepted
//   repeat_pulse   one-cycle strobe at the auto-repeat rate while held
//
// All outputs come straight from flops.
//
// Timing for a clean edge on KEY first sampled at clock edge E0: the
// synchronized level reaches the FSM at E2, and the strobe (together with the
// change on pressed) appears after edge E(2+DEBOUNCE_CYCLES).
//
// Each channel's FSM state lives in gen_key[k].state and is reachable by
// hierarchical reference for checkers and debug.
// -----------------------------------------------------------------------------
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                CLOCK50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);

  // ---------------------------------------------------------------------------
  // Counter sizing: each counter is just wide enough to hold its largest value.
  // ---------------------------------------------------------------------------
  localparam int DCW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCW = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);

  localparam logic [DCW-1:0] DB_TARGET  = DCW'(DEBOUNCE_CYCLES);
  localparam logic [RCW-1:0] RPT_TARGET = RCW'(REPEAT_DELAY);

  // After each repeat strobe the repeat counter restarts REPEAT_PERIOD short
  // of the target so the next strobe lands REPEAT_PERIOD cycles later. A
  // period longer than the initial delay cannot be expressed that way, so the
  // reload clamps at 0 and such a key repeats every REPEAT_DELAY cycles.
  localparam int RELOAD_VAL = (REPEAT_DELAY > REPEAT_PERIOD) ?
                              (REPEAT_DELAY - REPEAT_PERIOD) : 0;
  localparam logic [RCW-1:0] RPT_RELOAD = RCW'(RELOAD_VAL);

  localparam bit REPEAT_ON = (REPEAT_DELAY != 0);

  // Pin level seen when the button is not touched.
  localparam logic RELEASED_LEVEL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_DB_RELEASE = 2'd3
  } key_state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer. Reset parks both stages at the released level so that a key
  // held across reset looks like a fresh press once reset lets go.
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] act;

  always_ff @(posedge CLOCK50) begin
    if (reset) begin
      sync1 <= {NUM_KEYS{RELEASED_LEVEL}};
      sync2 <= {NUM_KEYS{RELEASED_LEVEL}};
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  // XOR with the released level maps "released" to 0 and "pressed" to 1 for
  // either pin polarity.
  assign act = sync2 ^ {NUM_KEYS{RELEASED_LEVEL}};

  // ---------------------------------------------------------------------------
  // Per-key debounce / repeat FSM.
  //
  //   IDLE        -> DB_PRESS    on act=1 (that sample counts as the first)
  //   DB_PRESS    -> IDLE        on any act=0 sample (qualification restarts)
  //               -> PRESSED     when DEBOUNCE_CYCLES further act=1 samples
  //                              have been seen; strobes press_pulse
  //   PRESSED     -> DB_RELEASE  on act=0; otherwise the repeat counter runs
  //   DB_RELEASE  -> PRESSED     on any act=1 sample; repeat counter kept as is
  //               -> IDLE        after the full qualification; strobes
  //                              release_pulse
  //
  // pressed stays 1 through DB_RELEASE, so release bounce never shows on the
  // level output. repeat_pulse is only ever set from PRESSED with act=1, which
  // keeps it apart from both press_pulse and release_pulse.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_KEYS; k++) begin : gen_key
    key_state_t     state;
    logic [DCW-1:0] dcnt;
    logic [RCW-1:0] rcnt;
    logic [DCW-1:0] dcnt_inc;
    logic [RCW-1:0] rcnt_inc;
    logic           pressed_r;
    logic           press_r;
    logic           release_r;
    logic           repeat_r;

    // Saturating increments: counters never wrap, whatever the parameters.
    assign dcnt_inc = (dcnt == {DCW{1'b1}}) ? dcnt : dcnt + DCW'(1);
    assign rcnt_inc = (rcnt == {RCW{1'b1}}) ? rcnt : rcnt + RCW'(1);

    always_ff @(posedge CLOCK50) begin
      if (reset) begin
        state     <= ST_IDLE;
        dcnt      <= '0;
        rcnt      <= '0;
        pressed_r <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        // Strobes default low so each one lasts exactly one cycle.
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;

        case (state)
          ST_IDLE: begin
            if (act[k]) begin
              state <= ST_DB_PRESS;
              dcnt  <= DCW'(1);
            end
          end

          ST_DB_PRESS: begin
            if (!act[k]) begin
              state <= ST_IDLE;
              dcnt  <= '0;
            end else if (dcnt == DB_TARGET) begin
              state     <= ST_PRESSED;
              dcnt      <= '0;
              rcnt      <= '0;
              pressed_r <= 1'b1;
              press_r   <= 1'b1;
            end else begin
              dcnt <= dcnt_inc;
            end
          end

          ST_PRESSED: begin
            if (!act[k]) begin
              state <= ST_DB_RELEASE;
              dcnt  <= DCW'(1);
            end else if (REPEAT_ON) begin
              // Strobe on the cycle the counter would reach the target and
              // reload instead, so the counter never exceeds REPEAT_DELAY.
              if (rcnt_inc == RPT_TARGET) begin
                repeat_r <= 1'b1;
                rcnt     <= RPT_RELOAD;
              end else begin
                rcnt <= rcnt_inc;
              end
            end
          end

          ST_DB_RELEASE: begin
            if (act[k]) begin
              // Bounce back to held: rcnt untouched so the repeat cadence
              // resumes where it stopped.
              state <= ST_PRESSED;
              dcnt  <= '0;
            end else if (dcnt == DB_TARGET) begin
              state     <= ST_IDLE;
              dcnt      <= '0;
              pressed_r <= 1'b0;
              release_r <= 1'b1;
            end else begin
              dcnt <= dcnt_inc;
            end
          end

          default: begin
            state <= ST_IDLE;
            dcnt  <= '0;
          end
        endcase
      end
    end

    assign pressed[k]       = pressed_r;
    assign press_pulse[k]   = press_r;
    assign release_pulse[k] = release_r;
    assign repeat_pulse[k]  = repeat_r;
  end

endmodule
